cordic_dir_encoder: RTL and testbench

- Upstream stage of CR_CORDIC. Converts a signed angle in radians into the 32-bit rotation-direction word `theta_x_di` that CR_CORDIC consumes.
- Works as a sequential angle-accumulation CORDIC: one iteration per clock, using a 32-entry arctangent ROM.
- Has a start/done handshake. Its outputs connect directly to CR_CORDIC's `theta_x_di`, `N` and `start` inputs.

---
 rtl/cordic_dir_encoder.sv | 182 ++++++++++++++++++
 tb/tb_cordic_dir_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_dir_encoder.sv
// cordic_dir_encoder
// Converts a signed Q2.13 angle (radians) into the 32-bit rotation-direction
// word consumed by CR_CORDIC. It runs an angle-accumulation CORDIC at one
// iteration per clock against a rounded arctangent table.
//
// Handshake: start is a one-cycle request and is sampled only while the block
// is idle; a start seen while busy is dropped, not queued. busy is high from
// the cycle after the request is accepted until the done cycle, inclusive.
// done is a one-cycle pulse. di_word, n_out, resid_out are valid from the
// done cycle and hold until the next done. range_err is captured when a
// request is accepted.
module cordic_dir_encoder #(
    parameter int ANG_W  = 16,
    parameter int RES_W  = 32,
    parameter int MAX_IT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ANG_W-1:0]  theta_in,
    input  logic [7:0]        N,
    output logic [MAX_IT-1:0] di_word,
    output logic [7:0]        n_out,
    output logic [RES_W-1:0]  resid_out,
    output logic              range_err,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter must hold 0..MAX_IT inclusive; the bit index only 0..MAX_IT-1
    localparam int IT_W  = $clog2(MAX_IT + 1);
    localparam int IDX_W = $clog2(MAX_IT);
    // Q2.13 -> Q2.29 alignment shift
    localparam int ALIGN = RES_W - ANG_W;

    // pi/2 in Q2.13 (round(1.5707963 * 8192))
    localparam logic signed [ANG_W-1:0] HALF_PI_POS = ANG_W'(12868);
    localparam logic signed [ANG_W-1:0] HALF_PI_NEG = ANG_W'(-12868);

    logic [1:0]        r_state;
    logic [RES_W-1:0]  r_resid;
    logic [MAX_IT-1:0] r_shift;
    logic [IT_W-1:0]   r_iter;
    logic [IT_W-1:0]   r_nc;
    logic [MAX_IT-1:0] r_di_word;
    logic [7:0]        r_n_out;
    logic [RES_W-1:0]  r_resid_out;
    logic              r_range_err;

    logic [IT_W-1:0]         w_nc;
    logic signed [ANG_W-1:0] w_theta_s;
    logic                    w_out_of_range;
    logic [RES_W-1:0]        w_atan;
    logic                    w_dir;
    logic [RES_W-1:0]        w_resid_next;
    logic                    w_iter_done;
    logic [IDX_W-1:0]        w_bit_idx;

    // Requested iteration count clamped to the width of the direction word
    assign w_nc = (N > 8'(MAX_IT)) ? IT_W'(MAX_IT) : N[IT_W-1:0];

    // Angle magnitude beyond pi/2 is flagged but still processed
    assign w_theta_s      = theta_in;
    assign w_out_of_range = (w_theta_s > HALF_PI_POS) || (w_theta_s < HALF_PI_NEG);

    // Direction follows the residual sign: non-negative residual rotates positive
    assign w_dir        = ~r_resid[RES_W-1];
    assign w_resid_next = w_dir ? (r_resid - w_atan) : (r_resid + w_atan);
    assign w_iter_done  = (r_iter == r_nc);
    // d_i lands MSB-first so the first iteration is di_word[MAX_IT-1]
    assign w_bit_idx    = IDX_W'(MAX_IT - 1) - r_iter[IDX_W-1:0];

    // atan(2^-i) in Q2.29, rounded to nearest; entries 30 and 31 round to 0
    always_comb begin
        w_atan = '0;
        case (r_iter[IDX_W-1:0])
            5'd0:  w_atan = 32'd421657428;
            5'd1:  w_atan = 32'd248918915;
            5'd2:  w_atan = 32'd131521918;
            5'd3:  w_atan = 32'd66762579;
            5'd4:  w_atan = 32'd33510843;
            5'd5:  w_atan = 32'd16771758;
            5'd6:  w_atan = 32'd8387925;
            5'd7:  w_atan = 32'd4194219;
            5'd8:  w_atan = 32'd2097141;
            5'd9:  w_atan = 32'd1048575;
            5'd10: w_atan = 32'd524288;
            5'd11: w_atan = 32'd262144;
            5'd12: w_atan = 32'd131072;
            5'd13: w_atan = 32'd65536;
            5'd14: w_atan = 32'd32768;
            5'd15: w_atan = 32'd16384;
            5'd16: w_atan = 32'd8192;
            5'd17: w_atan = 32'd4096;
            5'd18: w_atan = 32'd2048;
            5'd19: w_atan = 32'd1024;
            5'd20: w_atan = 32'd512;
            5'd21: w_atan = 32'd256;
            5'd22: w_atan = 32'd128;
            5'd23: w_atan = 32'd64;
            5'd24: w_atan = 32'd32;
            5'd25: w_atan = 32'd16;
            5'd26: w_atan = 32'd8;
            5'd27: w_atan = 32'd4;
            5'd28: w_atan = 32'd2;
            5'd29: w_atan = 32'd1;
            5'd30: w_atan = 32'd0;
            5'd31: w_atan = 32'd0;
            default: w_atan = '0;
        endcase
    end

    // State sequencing: IDLE -> RUN (Nc iterations plus one exit cycle) -> DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_RUN;
                S_RUN:   if (w_iter_done) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Iteration datapath: residual, iteration counter and the direction shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resid     <= '0;
            r_shift     <= '0;
            r_iter      <= '0;
            r_nc        <= '0;
            r_range_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (start) begin
                    // Sign extension then <<ALIGN keeps exactly the angle bits on top
                    r_resid     <= {theta_in, {ALIGN{1'b0}}};
                    r_shift     <= '0;
                    r_iter      <= '0;
                    r_nc        <= w_nc;
                    r_range_err <= w_out_of_range;
                end
            end else if (r_state == S_RUN) begin
                if (!w_iter_done) begin
                    r_resid            <= w_resid_next;
                    r_shift[w_bit_idx] <= w_dir;
                    r_iter             <= r_iter + IT_W'(1);
                end
            end
        end
    end

    // Result registers: updated only on the RUN exit so a partial word is never visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_di_word   <= '0;
            r_n_out     <= '0;
            r_resid_out <= '0;
        end else if ((r_state == S_RUN) && w_iter_done) begin
            r_di_word   <= r_shift;
            r_n_out     <= 8'(r_nc);
            r_resid_out <= r_resid;
        end
    end

    assign di_word   = r_di_word;
    assign n_out     = r_n_out;
    assign resid_out = r_resid_out;
    assign range_err = r_range_err;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cordic_dir_encoder.sv
// Directed plus randomized bench for cordic_dir_encoder. The reference model
// builds its own arctangent table with real arithmetic and walks the
// direction decisions with plain integers.
module tb_cordic_dir_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] theta_in;
    logic [7:0]  N;
    logic [31:0] di_word;
    logic [7:0]  n_out;
    logic [31:0] resid_out;
    logic        range_err;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0;
    int rom [32];

    cordic_dir_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .theta_in  (theta_in),
        .N         (N),
        .di_word   (di_word),
        .n_out     (n_out),
        .resid_out (resid_out),
        .range_err (range_err),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / pulse monitor
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // scoreboard compare
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: residual walk with the angle in units of 2^-29 rad
    task automatic model(input logic [15:0] th, input logic [7:0] n,
                         output logic [31:0] e_di, output logic [7:0] e_n,
                         output logic [31:0] e_res, output logic e_rerr, output int e_lat);
        int nc;
        int z;
        int a;
        nc = (n > 8'd32) ? 32 : int'(n);
        a  = int'($signed(th));
        z  = a * 65536;
        e_di = '0;
        for (int i = 0; i < nc; i++) begin
            if (z >= 0) begin
                e_di[31-i] = 1'b1;
                z = z - rom[i];
            end else begin
                z = z + rom[i];
            end
        end
        e_n    = 8'(nc);
        e_res  = z;
        e_rerr = (a > 12868) || (a < -12868);
        e_lat  = nc + 1;
    endtask

    // driver: one request, optional extra start at cycle extra_at, waits for done
    task automatic run(input logic [15:0] th, input logic [7:0] n, input int extra_at, output int lat);
        logic [31:0] prev_di;
        logic [31:0] prev_res;
        bit          stable;
        bit          seen;
        @(posedge clk); #1;
        theta_in = th;
        N        = n;
        start    = 1'b1;
        prev_di  = di_word;
        prev_res = resid_out;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        lat    = 0;
        seen   = 1'b0;
        stable = 1'b1;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == extra_at) begin
                start    = 1'b1;
                theta_in = 16'h0800;
                N        = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
            else if (di_word !== prev_di || resid_out !== prev_res) stable = 1'b0;
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("hold_during_run", stable, 1'b1);
    endtask

    task automatic check_result(input string tag, input logic [15:0] th, input logic [7:0] n, input int lat);
        logic [31:0] e_di;
        logic [7:0]  e_n;
        logic [31:0] e_res;
        logic        e_rerr;
        int          e_lat;
        model(th, n, e_di, e_n, e_res, e_rerr, e_lat);
        check({tag, "_di"}, di_word, e_di);
        check({tag, "_n"}, n_out, e_n);
        check({tag, "_res"}, resid_out, e_res);
        check({tag, "_rerr"}, range_err, e_rerr);
        check({tag, "_lat"}, lat, e_lat);
    endtask

    task automatic step_after_done(input string tag);
        @(posedge clk); #1;
        check({tag, "_done_width"}, done, 1'b0);
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        int          lat;
        int          r;
        int          dc;
        int          t;
        bit          busy_seen;
        logic [31:0] h_di;
        logic [31:0] h_res;
        logic [15:0] th;
        logic [7:0]  n;

        for (int i = 0; i < 32; i++) begin
            real v;
            v = $atan(2.0 ** (-i)) * 536870912.0;
            rom[i] = int'($floor(v + 0.5 - 1.0e-6));
        end

        // reset
        rst = 1'b1; start = 1'b0; theta_in = '0; N = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_di", di_word, 32'h0);
        check("rst_n", n_out, 8'h0);
        check("rst_res", resid_out, 32'h0);
        check("rst_rerr", range_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;

        // 70 degrees, full length
        run(16'h2718, 8'd32, -1, lat);
        check_result("deg70", 16'h2718, 8'd32, lat);
        check("deg70_lat33", lat, 33);
        check("deg70_n32", n_out, 8'd32);
        check("deg70_top8", di_word[31:24], 8'b1101_1101);
        r = $signed(resid_out);
        check("deg70_conv", (r <= 4) && (r >= -4), 1'b1);
        check("deg70_rerr", range_err, 1'b0);
        step_after_done("deg70");

        // reset in the middle of RUN
        @(posedge clk); #1;
        theta_in = 16'h2718; N = 8'd32; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        dc  = done_cnt;
        rst = 1'b1;
        #1;
        check("midrst_di", di_word, 32'h0);
        check("midrst_n", n_out, 8'h0);
        check("midrst_res", resid_out, 32'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_state", dbg_state, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        busy_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        check("midrst_busy_after", busy_seen, 1'b0);
        check("midrst_no_done", done_cnt, dc);

        // zero angle
        run(16'h0000, 8'd32, -1, lat);
        check_result("zero", 16'h0000, 8'd32, lat);
        check("zero_b31", di_word[31], 1'b1);
        check("zero_b30", di_word[30], 1'b0);

        // -70 degrees
        run(16'hD8E8, 8'd32, -1, lat);
        check_result("neg70", 16'hD8E8, 8'd32, lat);
        check("neg70_top8", di_word[31:24], 8'b0010_0010);

        // N clamp
        run(16'h1555, 8'd200, -1, lat);
        check_result("clamp", 16'h1555, 8'd200, lat);
        check("clamp_n", n_out, 8'd32);
        check("clamp_lat", lat, 33);

        // short runs
        run(16'h2718, 8'd4, -1, lat);
        check_result("n4", 16'h2718, 8'd4, lat);
        check("n4_di", di_word, 32'hD000_0000);
        check("n4_lat", lat, 5);
        step_after_done("n4");

        run(16'h2718, 8'd0, -1, lat);
        check_result("n0", 16'h2718, 8'd0, lat);
        check("n0_di", di_word, 32'h0);
        check("n0_lat", lat, 1);
        step_after_done("n0");

        // second start while busy is dropped
        dc = done_cnt;
        run(16'h1234, 8'd20, 10, lat);
        check_result("hs", 16'h1234, 8'd20, lat);
        h_di  = di_word;
        h_res = resid_out;
        repeat (25) @(posedge clk);
        #1;
        check("hs_one_done", done_cnt - dc, 1);
        check("hs_hold_di", di_word, h_di);
        check("hs_hold_res", resid_out, h_res);
        check("hs_no_queue", busy, 1'b0);

        // range flag
        run(16'h3400, 8'd32, -1, lat);
        check_result("oor", 16'h3400, 8'd32, lat);
        check("oor_rerr", range_err, 1'b1);
        run(16'h3244, 8'd32, -1, lat);
        check_result("edge", 16'h3244, 8'd32, lat);
        check("edge_rerr", range_err, 1'b0);

        // randomized requests
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                th = 16'($urandom);
            end else begin
                t  = int'($urandom_range(0, 25736)) - 12868;
                th = t[15:0];
            end
            if ($urandom_range(0, 4) == 0) n = 8'($urandom);
            else n = 8'($urandom_range(0, 40));
            run(th, n, -1, lat);
            check_result("rand", th, n, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
